// File: rtl/wave_pacer_if.sv
// -----------------------------------------------------------------------------
// wave_pacer_if
//   Sample handshake between wave_pacer and the AD5791 controller (dacout).
//   A transfer completes in any cycle where tx_dv && !tx_waitrequest.
//
//   Signals:
//     tx_dv           sample offered to dacout (driven by wave_pacer)
//     tx_data         sample value, stable while tx_dv is high
//     tx_waitrequest  dacout busy (driven by dacout)
//
//   Modports:
//     master  wave_pacer side
//     slave   dacout side
// -----------------------------------------------------------------------------
interface wave_pacer_if #(
    parameter int DATA_NBIT = 20
);
    logic                 tx_dv;
    logic [DATA_NBIT-1:0] tx_data;
    logic                 tx_waitrequest;

    modport master (
        output tx_dv,
        output tx_data,
        input  tx_waitrequest
    );

    modport slave (
        input  tx_dv,
        input  tx_data,
        output tx_waitrequest
    );
endinterface

// File: rtl/wave_pacer.sv
// -----------------------------------------------------------------------------
// wave_pacer
//   Sample-rate pacer and elastic buffer between the gain/offset stage and the
//   AD5791 controller. Bursty SDRAM samples are absorbed in a FIFO, SDRAM reads
//   are throttled through fill_req, and one sample is released per programmable
//   tick on the tx handshake. Underrun, overflow and late ticks are reported as
//   sticky flags.
//
//   Optional feature macro: WAVE_PACER_HOLD_LAST_EN
//     defined   - an underrun tick re-issues the last sample sent (0 after reset)
//     undefined - an underrun tick offers nothing; the DAC keeps its code
//
//   Ports:
//     mclk        clock
//     rst_n       synchronous active-low reset
//     en          run enable
//     rate_div    one tick every rate_div+1 cycles (sampled at counter reload)
//     in_dv       input sample valid (no backpressure)
//     in_data     input sample
//     fill_req    upstream may issue SDRAM reads
//     tx          sample handshake to dacout (wave_pacer_if.master)
//     level       FIFO occupancy
//     running     high while in RUN
//     underrun    sticky: tick found the FIFO empty
//     overflow    sticky: sample dropped on a full FIFO
//     late        sticky: tick arrived while a transfer was still pending
//     clr_status  clears the sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module wave_pacer #(
    parameter int DATA_NBIT  = 20,
    parameter int DEPTH_LOG2 = 6,
    parameter int DIV_NBIT   = 16,
    parameter int REQ_MARGIN = 8
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DIV_NBIT-1:0]   rate_div,
    input  logic                  in_dv,
    input  logic [DATA_NBIT-1:0]  in_data,
    output logic                  fill_req,
    wave_pacer_if.master          tx,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  running,
    output logic                  underrun,
    output logic                  overflow,
    output logic                  late,
    input  logic                  clr_status
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] HALF_LVL = LVL_W'(DEPTH / 2);
    localparam logic [LVL_W-1:0] REQ_LVL  = LVL_W'(DEPTH - REQ_MARGIN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_STOP
    } state_t;

    state_t                state_q, state_d;
    logic                  en_q;
    logic [DIV_NBIT-1:0]   cnt_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  tx_dv_q;
    logic [DATA_NBIT-1:0]  tx_data_q;
    logic                  running_q;
    logic                  underrun_q, overflow_q, late_q;
    logic [DATA_NBIT-1:0]  mem_q [DEPTH];

    logic fifo_live;
    logic full, empty, pending, tick;
    logic push, drop, pop, starve, late_ev;

    // Next state
    // NOTE: every variable assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en && !en_q) state_d = ST_PRIME;
            ST_PRIME: begin
                if (!en)                       state_d = ST_STOP;
                else if (level_q >= HALF_LVL)  state_d = ST_RUN;
            end
            ST_RUN:   if (!en) state_d = ST_STOP;
            // Leave STOP once nothing is left waiting on dacout.
            ST_STOP:  if (!(tx_dv_q && tx.tx_waitrequest)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The FIFO only holds data in PRIME/RUN while enabled; dropping en flushes it
    // on the same edge that enters STOP.
    assign fifo_live = ((state_q == ST_PRIME) || (state_q == ST_RUN)) && en;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign pending = tx_dv_q && tx.tx_waitrequest;
    assign tick    = (state_q == ST_RUN) && en && (cnt_q == '0);

    // Fullness is judged on the pre-pop level, so a simultaneous pop never
    // rescues a write into a full FIFO.
    assign push    = fifo_live && in_dv && !full;
    assign drop    = fifo_live && in_dv && full;
    assign pop     = tick && !pending && !empty;
    assign starve  = tick && !pending && empty;
    assign late_ev = tick && pending;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tx_dv_q    <= 1'b0;
            tx_data_q  <= '0;
            running_q  <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en;
            running_q <= (state_d == ST_RUN);

            // Counter sits at 0 outside RUN so the entry cycle ticks at once.
            if (state_q != ST_RUN) begin
                cnt_q <= '0;
            end else if (tick) begin
                cnt_q <= rate_div;
            end else begin
                cnt_q <= cnt_q - DIV_NBIT'(1);
            end

            if (!fifo_live) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
                case ({push, pop})
                    2'b10:   level_q <= level_q + LVL_W'(1);
                    2'b01:   level_q <= level_q - LVL_W'(1);
                    default: level_q <= level_q;
                endcase
            end

            // Accepted transfer drops tx_dv; a tick in the same cycle may
            // re-assert it below (later assignment wins).
            if (tx_dv_q && !tx.tx_waitrequest) tx_dv_q <= 1'b0;
            if (pop) begin
                tx_dv_q   <= 1'b1;
                tx_data_q <= mem_q[rd_ptr_q];
            end
`ifdef WAVE_PACER_HOLD_LAST_EN
            // tx_data_q still holds the last sample sent, so re-offer it.
            else if (starve) begin
                tx_dv_q <= 1'b1;
            end
`endif

            if (clr_status) begin
                underrun_q <= 1'b0;
                overflow_q <= 1'b0;
                late_q     <= 1'b0;
            end
            if (starve)  underrun_q <= 1'b1;
            if (drop)    overflow_q <= 1'b1;
            if (late_ev) late_q     <= 1'b1;
        end
    end

    // NOTE: the sample storage has no reset; the pointers and level are reset,
    // so stale contents are never read.
    always_ff @(posedge mclk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign fill_req   = en && ((state_q == ST_PRIME) || (state_q == ST_RUN)) &&
                        (level_q < REQ_LVL);
    assign tx.tx_dv   = tx_dv_q;
    assign tx.tx_data = tx_data_q;
    assign level      = level_q;
    assign running    = running_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;
    assign late       = late_q;

endmodule
